// File: rtl/decode_stage.sv
// Pipelined MIPS decode stage: valid/ready handshake, one-cycle registered control bundle.
// Optional load-use interlock enabled by defining DECODE_HAZARD_EN.
module decode_stage #(
    parameter int XLEN     = 32,
    parameter int ALUOP_W  = 3,
    parameter int LOAD_LAT = 1
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_if_valid,
    output logic               o_if_ready,
    input  logic [31:0]        i_instruction,
    input  logic [31:0]        i_pc_in,
    input  logic               i_flush,
    output logic               o_id_valid,
    input  logic               i_ex_ready,
    output logic [4:0]         o_rs,
    output logic [4:0]         o_rt,
    output logic [4:0]         o_wr_addr,
    output logic               o_reg_wr,
    output logic               o_mem_rd,
    output logic               o_dm_wr,
    output logic               o_alu_src,
    output logic               o_branch,
    output logic               o_branch_ne,
    output logic               o_jump,
    output logic               o_jump_reg,
    output logic               o_link,
    output logic               o_illegal,
    output logic [ALUOP_W-1:0] o_alu_op,
    output logic [XLEN-1:0]    o_imm_ext,
    output logic [25:0]        o_imm26,
    output logic [31:0]        o_pc_out
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_JR   = 6'b001000;

    localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(0);
    localparam logic [ALUOP_W-1:0] ALU_SUB = ALUOP_W'(1);
    localparam logic [ALUOP_W-1:0] ALU_SLT = ALUOP_W'(2);
    localparam logic [ALUOP_W-1:0] ALU_XOR = ALUOP_W'(3);

    if (LOAD_LAT < 1 || LOAD_LAT > 3) begin : g_bad_load_lat
        $error("decode_stage: LOAD_LAT must be in 1..3");
    end

    typedef struct packed {
        logic [4:0]         rs;
        logic [4:0]         rt;
        logic [4:0]         wr_addr;
        logic               reg_wr;
        logic               mem_rd;
        logic               dm_wr;
        logic               alu_src;
        logic               branch;
        logic               branch_ne;
        logic               jump;
        logic               jump_reg;
        logic               link;
        logic               illegal;
        logic [ALUOP_W-1:0] alu_op;
        logic [XLEN-1:0]    imm_ext;
        logic [25:0]        imm26;
        logic [31:0]        pc;
    } bundle_t;

    logic [5:0]  w_opcode;
    logic [5:0]  w_funct;
    logic [4:0]  w_rs;
    logic [4:0]  w_rt;
    logic [4:0]  w_rd;
    logic [15:0] w_imm16;
    bundle_t     w_dec;
    bundle_t     r_out;
    logic        r_id_valid;
    logic        w_advance;
    logic        w_accept;
    logic        w_stall;

    assign w_opcode = i_instruction[31:26];
    assign w_rs     = i_instruction[25:21];
    assign w_rt     = i_instruction[20:16];
    assign w_rd     = i_instruction[15:11];
    assign w_funct  = i_instruction[5:0];
    assign w_imm16  = i_instruction[15:0];

    always_comb begin
        w_dec         = '0;
        w_dec.rs      = w_rs;
        w_dec.rt      = w_rt;
        w_dec.imm26   = i_instruction[25:0];
        w_dec.pc      = i_pc_in;
        w_dec.imm_ext = {{(XLEN-16){w_imm16[15]}}, w_imm16};
        case (w_opcode)
            OP_RTYPE: begin
                w_dec.wr_addr = w_rd;
                case (w_funct)
                    FN_ADD, FN_ADDU: w_dec.reg_wr = 1'b1;
                    FN_SUB: begin w_dec.reg_wr = 1'b1; w_dec.alu_op = ALU_SUB; end
                    FN_SLT: begin w_dec.reg_wr = 1'b1; w_dec.alu_op = ALU_SLT; end
                    FN_JR:  w_dec.jump_reg = 1'b1;
                    default: begin w_dec.illegal = 1'b1; w_dec.wr_addr = 5'd0; end
                endcase
            end
            OP_ADDI, OP_ADDIU: begin
                w_dec.wr_addr = w_rt; w_dec.reg_wr = 1'b1; w_dec.alu_src = 1'b1;
            end
            OP_XORI: begin
                w_dec.wr_addr = w_rt; w_dec.reg_wr = 1'b1; w_dec.alu_src = 1'b1;
                w_dec.alu_op  = ALU_XOR;
                w_dec.imm_ext = XLEN'(w_imm16);
            end
            OP_LW: begin
                w_dec.wr_addr = w_rt; w_dec.reg_wr = 1'b1; w_dec.alu_src = 1'b1;
                w_dec.mem_rd  = 1'b1;
            end
            OP_SW:  begin w_dec.dm_wr = 1'b1; w_dec.alu_src = 1'b1; end
            OP_BEQ: begin w_dec.branch = 1'b1; w_dec.alu_op = ALU_SUB; end
            OP_BNE: begin
                w_dec.branch = 1'b1; w_dec.branch_ne = 1'b1; w_dec.alu_op = ALU_SUB;
            end
            OP_J:   w_dec.jump = 1'b1;
            OP_JAL: begin
                w_dec.jump = 1'b1; w_dec.link = 1'b1;
                w_dec.wr_addr = 5'd31; w_dec.reg_wr = 1'b1;
            end
            default: w_dec.illegal = 1'b1;
        endcase
        // Writes to $0 are architecturally discarded, so never request them.
        if (w_dec.wr_addr == 5'd0) w_dec.reg_wr = 1'b0;
    end

    assign w_advance  = ~r_id_valid | i_ex_ready;
    assign o_if_ready = ~i_reset & ~i_flush & ~w_stall & w_advance;
    assign w_accept   = i_if_valid & o_if_ready;

`ifdef DECODE_HAZARD_EN
    logic [4:0] r_pend_dst;
    logic [1:0] r_pend_cnt;
    logic       w_reads_rs;
    logic       w_reads_rt;

    always_comb begin
        w_reads_rs = 1'b0;
        w_reads_rt = 1'b0;
        case (w_opcode)
            OP_RTYPE: begin
                case (w_funct)
                    FN_ADD, FN_ADDU, FN_SUB, FN_SLT: begin w_reads_rs = 1'b1; w_reads_rt = 1'b1; end
                    FN_JR:   w_reads_rs = 1'b1;
                    default: ;
                endcase
            end
            OP_ADDI, OP_ADDIU, OP_XORI, OP_LW: w_reads_rs = 1'b1;
            OP_SW, OP_BEQ, OP_BNE: begin w_reads_rs = 1'b1; w_reads_rt = 1'b1; end
            default: ;
        endcase
    end

    assign w_stall = (r_pend_cnt != 2'd0) & i_if_valid &
                     ((w_reads_rs & (w_rs == r_pend_dst)) | (w_reads_rt & (w_rt == r_pend_dst)));

    // The newest load always owns the tracker; the count only drains when the output slot moves.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pend_dst <= 5'd0;
            r_pend_cnt <= 2'd0;
        end else if (i_flush) begin
            r_pend_cnt <= 2'd0;
        end else if (w_accept && (w_opcode == OP_LW) && (w_rt != 5'd0)) begin
            r_pend_dst <= w_rt;
            r_pend_cnt <= 2'(LOAD_LAT);
        end else if (w_advance && (r_pend_cnt != 2'd0)) begin
            r_pend_cnt <= r_pend_cnt - 2'd1;
        end
    end
`else
    assign w_stall = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_out      <= '0;
            r_id_valid <= 1'b0;
        end else if (i_flush) begin
            r_id_valid <= 1'b0;
        end else if (w_advance) begin
            r_id_valid <= w_accept;
            if (w_accept) r_out <= w_dec;
        end
    end

    assign o_id_valid  = r_id_valid;
    assign o_rs        = r_out.rs;
    assign o_rt        = r_out.rt;
    assign o_wr_addr   = r_out.wr_addr;
    assign o_reg_wr    = r_out.reg_wr;
    assign o_mem_rd    = r_out.mem_rd;
    assign o_dm_wr     = r_out.dm_wr;
    assign o_alu_src   = r_out.alu_src;
    assign o_branch    = r_out.branch;
    assign o_branch_ne = r_out.branch_ne;
    assign o_jump      = r_out.jump;
    assign o_jump_reg  = r_out.jump_reg;
    assign o_link      = r_out.link;
    assign o_illegal   = r_out.illegal;
    assign o_alu_op    = r_out.alu_op;
    assign o_imm_ext   = r_out.imm_ext;
    assign o_imm26     = r_out.imm26;
    assign o_pc_out    = r_out.pc;

endmodule

// File: tb/tb_decode_stage.sv
// Directed testbench for decode_stage; expected bubble count follows DECODE_HAZARD_EN.
module tb_decode_stage;

    localparam int LL = 2;
`ifdef DECODE_HAZARD_EN
    localparam int EXP_BUB = LL;
`else
    localparam int EXP_BUB = 0;
`endif

    logic        i_clk = 1'b0;
    logic        i_reset, i_if_valid, i_flush, i_ex_ready;
    logic [31:0] i_instruction, i_pc_in;
    logic        o_if_ready, o_id_valid;
    logic [4:0]  o_rs, o_rt, o_wr_addr;
    logic        o_reg_wr, o_mem_rd, o_dm_wr, o_alu_src, o_branch, o_branch_ne;
    logic        o_jump, o_jump_reg, o_link, o_illegal;
    logic [2:0]  o_alu_op;
    logic [31:0] o_imm_ext, o_pc_out;
    logic [25:0] o_imm26;

    int total  = 0;
    int passed = 0;

    decode_stage #(.XLEN(32), .ALUOP_W(3), .LOAD_LAT(LL)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_if_valid(i_if_valid), .o_if_ready(o_if_ready),
        .i_instruction(i_instruction), .i_pc_in(i_pc_in), .i_flush(i_flush),
        .o_id_valid(o_id_valid), .i_ex_ready(i_ex_ready), .o_rs(o_rs), .o_rt(o_rt),
        .o_wr_addr(o_wr_addr), .o_reg_wr(o_reg_wr), .o_mem_rd(o_mem_rd), .o_dm_wr(o_dm_wr),
        .o_alu_src(o_alu_src), .o_branch(o_branch), .o_branch_ne(o_branch_ne),
        .o_jump(o_jump), .o_jump_reg(o_jump_reg), .o_link(o_link), .o_illegal(o_illegal),
        .o_alu_op(o_alu_op), .o_imm_ext(o_imm_ext), .o_imm26(o_imm26), .o_pc_out(o_pc_out)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_reset();
        logic [9:0] ctrl;
        i_reset = 1'b1; i_if_valid = 1'b1; i_flush = 1'b0; i_ex_ready = 1'b1;
        i_instruction = 32'h03E08820; i_pc_in = 32'h40;
        for (int c = 0; c < 3; c++) begin
            tick();
            ctrl = {o_reg_wr, o_mem_rd, o_dm_wr, o_alu_src, o_branch, o_branch_ne,
                    o_jump, o_jump_reg, o_link, o_illegal};
            total++; if (o_if_ready !== 1'b0) $display("[TB] FAIL rst_if_ready got %b exp 0", o_if_ready); else passed++;
            total++; if (o_id_valid !== 1'b0) $display("[TB] FAIL rst_id_valid got %b exp 0", o_id_valid); else passed++;
            total++; if (ctrl !== 10'd0) $display("[TB] FAIL rst_ctrl got %b exp 0", ctrl); else passed++;
            total++; if ({o_wr_addr, o_imm_ext, o_pc_out} !== 69'd0) $display("[TB] FAIL rst_data got %h exp 0", {o_wr_addr, o_imm_ext, o_pc_out}); else passed++;
        end
        i_reset = 1'b0;
        #1;
        total++; if (o_if_ready !== 1'b1) $display("[TB] FAIL post_rst_if_ready got %b exp 1", o_if_ready); else passed++;
        i_if_valid = 1'b0;
        tick();
        total++; if (o_id_valid !== 1'b0) $display("[TB] FAIL post_rst_idle got %b exp 0", o_id_valid); else passed++;
    endtask

    task automatic test_back_to_back();
        i_ex_ready = 1'b1; i_if_valid = 1'b1;
        i_instruction = 32'h03E08820; i_pc_in = 32'h100;   // add $17,$31,$0
        tick();
        total++; if (o_id_valid !== 1'b1) $display("[TB] FAIL add_valid got %b exp 1", o_id_valid); else passed++;
        total++; if (o_wr_addr !== 5'd17) $display("[TB] FAIL add_wr_addr got %0d exp 17", o_wr_addr); else passed++;
        total++; if ({o_reg_wr, o_alu_src} !== 2'b10) $display("[TB] FAIL add_regwr_alusrc got %b exp 10", {o_reg_wr, o_alu_src}); else passed++;
        total++; if ({o_rs, o_alu_op} !== {5'd31, 3'd0}) $display("[TB] FAIL add_rs_aluop got %h exp %h", {o_rs, o_alu_op}, {5'd31, 3'd0}); else passed++;
        total++; if (o_pc_out !== 32'h100) $display("[TB] FAIL add_pc got %h exp 100", o_pc_out); else passed++;
        i_instruction = 32'h2210AAAA; i_pc_in = 32'h104;   // addi $16,$16,-21846
        #1;
        total++; if (o_if_ready !== 1'b1) $display("[TB] FAIL b2b_if_ready got %b exp 1", o_if_ready); else passed++;
        tick();
        total++; if ({o_id_valid, o_wr_addr, o_reg_wr, o_alu_src} !== {1'b1, 5'd16, 1'b1, 1'b1}) $display("[TB] FAIL addi_ctrl got %b exp 1100001 1", {o_id_valid, o_wr_addr, o_reg_wr, o_alu_src}); else passed++;
        total++; if (o_imm_ext !== 32'hFFFFAAAA) $display("[TB] FAIL addi_imm got %h exp FFFFAAAA", o_imm_ext); else passed++;
        total++; if (o_pc_out !== 32'h104) $display("[TB] FAIL addi_pc got %h exp 104", o_pc_out); else passed++;
        i_instruction = 32'h38C58001; i_pc_in = 32'h108;   // xori $5,$6,0x8001
        tick();
        total++; if (o_imm_ext !== 32'h00008001) $display("[TB] FAIL xori_imm got %h exp 00008001", o_imm_ext); else passed++;
        total++; if ({o_alu_op, o_wr_addr, o_alu_src} !== {3'd3, 5'd5, 1'b1}) $display("[TB] FAIL xori_ctrl got %b exp %b", {o_alu_op, o_wr_addr, o_alu_src}, {3'd3, 5'd5, 1'b1}); else passed++;
        i_instruction = 32'h00641022; i_pc_in = 32'h10C;   // sub $2,$3,$4
        tick();
        total++; if ({o_alu_op, o_wr_addr, o_reg_wr} !== {3'd1, 5'd2, 1'b1}) $display("[TB] FAIL sub_ctrl got %b exp %b", {o_alu_op, o_wr_addr, o_reg_wr}, {3'd1, 5'd2, 1'b1}); else passed++;
        i_instruction = 32'h0064102A; i_pc_in = 32'h110;   // slt $2,$3,$4
        tick();
        total++; if (o_alu_op !== 3'd2) $display("[TB] FAIL slt_aluop got %0d exp 2", o_alu_op); else passed++;
        i_instruction = 32'h00220020; i_pc_in = 32'h114;   // add $0,$1,$2
        tick();
        total++; if ({o_reg_wr, o_wr_addr} !== 6'd0) $display("[TB] FAIL zero_dst got %b exp 0", {o_reg_wr, o_wr_addr}); else passed++;
        i_if_valid = 1'b0;
        tick();
        total++; if (o_id_valid !== 1'b0) $display("[TB] FAIL drain_valid got %b exp 0", o_id_valid); else passed++;
    endtask

    task automatic test_control_flow();
        i_ex_ready = 1'b1; i_if_valid = 1'b1;
        i_instruction = 32'h0C100000; i_pc_in = 32'h200;   // jal 0x0100000
        tick();
        total++; if ({o_link, o_jump, o_reg_wr, o_wr_addr} !== {3'b111, 5'd31}) $display("[TB] FAIL jal_ctrl got %b exp 11111111", {o_link, o_jump, o_reg_wr, o_wr_addr}); else passed++;
        total++; if (o_imm26 !== 26'h0100000) $display("[TB] FAIL jal_imm26 got %h exp 0100000", o_imm26); else passed++;
        i_instruction = 32'h08100000; i_pc_in = 32'h204;   // j 0x0100000
        tick();
        total++; if ({o_jump, o_reg_wr, o_link, o_wr_addr} !== {3'b100, 5'd0}) $display("[TB] FAIL j_ctrl got %b exp 10000000", {o_jump, o_reg_wr, o_link, o_wr_addr}); else passed++;
        i_instruction = 32'h03E00008; i_pc_in = 32'h208;   // jr $31
        tick();
        total++; if ({o_jump_reg, o_reg_wr, o_jump, o_rs} !== {3'b100, 5'd31}) $display("[TB] FAIL jr_ctrl got %b exp 10011111", {o_jump_reg, o_reg_wr, o_jump, o_rs}); else passed++;
        i_instruction = 32'h1422FFFF; i_pc_in = 32'h20C;   // bne $1,$2,-1
        tick();
        total++; if ({o_branch, o_branch_ne, o_alu_op, o_reg_wr} !== {2'b11, 3'd1, 1'b0}) $display("[TB] FAIL bne_ctrl got %b exp 110010", {o_branch, o_branch_ne, o_alu_op, o_reg_wr}); else passed++;
        total++; if (o_imm_ext !== 32'hFFFFFFFF) $display("[TB] FAIL bne_imm got %h exp FFFFFFFF", o_imm_ext); else passed++;
        i_instruction = 32'hAD280004; i_pc_in = 32'h210;   // sw $8,4($9)
        tick();
        total++; if ({o_dm_wr, o_alu_src, o_reg_wr, o_mem_rd} !== 4'b1100) $display("[TB] FAIL sw_ctrl got %b exp 1100", {o_dm_wr, o_alu_src, o_reg_wr, o_mem_rd}); else passed++;
        i_if_valid = 1'b0;
        tick();
    endtask

    task automatic test_illegal();
        i_ex_ready = 1'b1; i_if_valid = 1'b1;
        i_instruction = 32'hFC000000; i_pc_in = 32'h300;   // opcode 111111
        tick();
        total++; if ({o_id_valid, o_illegal} !== 2'b11) $display("[TB] FAIL illop_flag got %b exp 11", {o_id_valid, o_illegal}); else passed++;
        total++; if ({o_reg_wr, o_dm_wr, o_branch, o_jump} !== 4'b0000) $display("[TB] FAIL illop_ctrl got %b exp 0000", {o_reg_wr, o_dm_wr, o_branch, o_jump}); else passed++;
        i_instruction = 32'h0000003F; i_pc_in = 32'h304;   // R-type funct 111111
        tick();
        total++; if ({o_id_valid, o_illegal, o_reg_wr, o_jump_reg} !== 4'b1100) $display("[TB] FAIL illfn_ctrl got %b exp 1100", {o_id_valid, o_illegal, o_reg_wr, o_jump_reg}); else passed++;
        i_if_valid = 1'b0;
        tick();
    endtask

    task automatic test_load_use();
        int bubbles = 0;
        bit found = 1'b0;
        i_ex_ready = 1'b1; i_if_valid = 1'b1;
        i_instruction = 32'h8D280000; i_pc_in = 32'h400;   // lw $8,0($9)
        tick();
        total++; if ({o_id_valid, o_mem_rd, o_wr_addr} !== {2'b11, 5'd8}) $display("[TB] FAIL lw_ctrl got %b exp 1101000", {o_id_valid, o_mem_rd, o_wr_addr}); else passed++;
        i_instruction = 32'h01085020; i_pc_in = 32'h404;   // add $10,$8,$8
        #1;
        total++; if (o_if_ready !== (EXP_BUB == 0)) $display("[TB] FAIL lu_if_ready got %b exp %b", o_if_ready, EXP_BUB == 0); else passed++;
        for (int c = 0; c < 8 && !found; c++) begin
            tick();
            if (o_id_valid && o_pc_out == 32'h404) found = 1'b1;
            else if (!o_id_valid) bubbles++;
        end
        total++; if (found !== 1'b1) $display("[TB] FAIL lu_timeout got %b exp 1", found); else passed++;
        total++; if (bubbles != EXP_BUB) $display("[TB] FAIL lu_bubbles got %0d exp %0d", bubbles, EXP_BUB); else passed++;
        total++; if (o_wr_addr !== 5'd10) $display("[TB] FAIL lu_reader_dst got %0d exp 10", o_wr_addr); else passed++;
        i_if_valid = 1'b0;
        tick();
    endtask

    task automatic test_lw_overwrite();
        i_ex_ready = 1'b1; i_if_valid = 1'b1;
        i_instruction = 32'h8D280000; i_pc_in = 32'h500;   // lw $8,0($9)
        tick();
        i_instruction = 32'h8D490000; i_pc_in = 32'h504;   // lw $9,0($10)
        #1;
        total++; if (o_if_ready !== 1'b1) $display("[TB] FAIL ow_lw2_ready got %b exp 1", o_if_ready); else passed++;
        tick();
        i_instruction = 32'h01085020; i_pc_in = 32'h508;   // add $10,$8,$8 (older load)
        #1;
        total++; if (o_if_ready !== 1'b1) $display("[TB] FAIL ow_add_ready got %b exp 1", o_if_ready); else passed++;
        tick();
        total++; if ({o_id_valid, o_pc_out} !== {1'b1, 32'h508}) $display("[TB] FAIL ow_add_out got %h exp 1_00000508", {o_id_valid, o_pc_out}); else passed++;
        i_if_valid = 1'b0;
        tick();
    endtask

    task automatic test_hold_flush();
        i_ex_ready = 1'b1; i_if_valid = 1'b1;
        i_instruction = 32'h03E08820; i_pc_in = 32'h600;
        tick();
        i_ex_ready = 1'b0;
        i_instruction = 32'h2210AAAA; i_pc_in = 32'h604;
        #1;
        total++; if (o_if_ready !== 1'b0) $display("[TB] FAIL hold_if_ready got %b exp 0", o_if_ready); else passed++;
        for (int c = 0; c < 2; c++) begin
            tick();
            total++; if ({o_id_valid, o_wr_addr, o_pc_out} !== {1'b1, 5'd17, 32'h600}) $display("[TB] FAIL hold_stable got %h exp %h", {o_id_valid, o_wr_addr, o_pc_out}, {1'b1, 5'd17, 32'h600}); else passed++;
            total++; if (o_if_ready !== 1'b0) $display("[TB] FAIL hold_ready got %b exp 0", o_if_ready); else passed++;
        end
        i_flush = 1'b1;
        tick();
        total++; if (o_id_valid !== 1'b0) $display("[TB] FAIL flush_drop got %b exp 0", o_id_valid); else passed++;
        i_flush = 1'b0; i_if_valid = 1'b0;
        #1;
        total++; if (o_if_ready !== 1'b1) $display("[TB] FAIL flush_reopen got %b exp 1", o_if_ready); else passed++;
        // A flush right after a load must also cancel its interlock.
        i_ex_ready = 1'b1; i_if_valid = 1'b1;
        i_instruction = 32'h8D280000; i_pc_in = 32'h700;
        tick();
        i_flush = 1'b1;
        i_instruction = 32'h01085020; i_pc_in = 32'h704;
        tick();
        total++; if (o_id_valid !== 1'b0) $display("[TB] FAIL flush_lw_drop got %b exp 0", o_id_valid); else passed++;
        i_flush = 1'b0;
        #1;
        total++; if (o_if_ready !== 1'b1) $display("[TB] FAIL flush_pend_clr got %b exp 1", o_if_ready); else passed++;
        tick();
        total++; if ({o_id_valid, o_pc_out} !== {1'b1, 32'h704}) $display("[TB] FAIL flush_next got %h exp 1_00000704", {o_id_valid, o_pc_out}); else passed++;
        i_if_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_stall();
        i_ex_ready = 1'b1; i_if_valid = 1'b1;
        i_instruction = 32'h8D280000; i_pc_in = 32'h800;
        tick();
        i_instruction = 32'h01085020; i_pc_in = 32'h804;
        i_reset = 1'b1;
        tick();
        total++; if ({o_id_valid, o_if_ready, o_wr_addr} !== 7'd0) $display("[TB] FAIL midrst_state got %b exp 0", {o_id_valid, o_if_ready, o_wr_addr}); else passed++;
        i_reset = 1'b0;
        #1;
        total++; if (o_if_ready !== 1'b1) $display("[TB] FAIL midrst_ready got %b exp 1", o_if_ready); else passed++;
        tick();
        total++; if ({o_id_valid, o_wr_addr} !== {1'b1, 5'd10}) $display("[TB] FAIL midrst_reader got %b exp 101010", {o_id_valid, o_wr_addr}); else passed++;
        i_if_valid = 1'b0;
        tick();
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        test_reset();
        test_back_to_back();
        test_control_flow();
        test_illegal();
        test_load_use();
        test_lw_overwrite();
        test_hold_flush();
        test_reset_mid_stall();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
# decode_stage

Pipelined, parametrised MIPS instruction decode stage sitting between fetch and execute. Accepts one 32-bit instruction per cycle under a valid/ready handshake, registers the decoded control bundle with one cycle of latency, and resolves the destination register and immediate extension internally. Adds a load-use interlock, branch flush and illegal-instruction flagging, which the single-cycle combinational decoder lacks.

## Interface
- XLEN, 32, width of extended immediate `imm_ext`
- ALUOP_W, 3, width of `alu_op`
- LOAD_LAT, 1, stall slots after a `lw` before a dependent reader may issue (1..3)
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- if_valid  in  1  fetch presents an instruction
- if_ready  out  1  stage accepts the instruction this cycle
- instruction  in  32  instruction word
- pc_in  in  32  address of `instruction`
- flush  in  1  squash held and incoming instructions (taken branch/jump)
- id_valid  out  1  decoded bundle valid
- ex_ready  in  1  execute consumes the bundle
- rs, rt  out  5  source register addresses
- wr_addr  out  5  resolved destination (rd / rt / 31)
- reg_wr, mem_rd, dm_wr, alu_src, branch, branch_ne, jump, jump_reg, link, illegal  out  1 each  control
- alu_op  out  ALUOP_W  0 ADD, 1 SUB, 2 SLT, 3 XOR
- imm_ext  out  XLEN  sign-extended imm16; zero-extended for `xori`
- imm26  out  26  jump target field
- pc_out  out  32  pc of the decoded instruction

## Operation
- Decoded set: R-type (funct 100000 add, 100001 addu, 100010 sub, 101010 slt, 001000 jr), addi 001000, addiu 001001, xori 001110, lw 100011, sw 101011, beq 000100, bne 000101, j 000010, jal 000011.
- wr_addr: R-type -> rd; addi/addiu/xori/lw -> rt; jal -> 31; others 0. reg_wr forced 0 when wr_addr == 0.
- alu_src = 1 for addi/addiu/xori/lw/sw. beq/bne: alu_op SUB, branch=1, branch_ne=1 for bne. jr: jump_reg=1, reg_wr=0. j: jump=1. jal: jump=1, link=1, reg_wr=1.
- Unknown opcode or unknown R-type funct: all write/branch/jump controls 0, illegal=1, id_valid=1 (execute raises the exception).
- Source usage: R-type and sw/beq/bne read rs and rt; jr, addi/addiu/xori/lw read rs only; j/jal read none.
- Handshake: transfer when if_valid & if_ready. if_ready = ~reset & ~flush & ~stall & (~id_valid | ex_ready). Output register holds while id_valid & ~ex_ready.
- Interlock: a transferred `lw` with rt != 0 loads pend_dst=rt, pend_cnt=LOAD_LAT. pend_cnt decrements in every cycle where the output slot advances (~id_valid | ex_ready). stall = pend_cnt != 0 & if_valid & (instruction reads pend_dst). While stalling and the slot advances, id_valid drops to 0 (bubble).
- Priority: reset > flush > stall > accept.

## Timing
- Reset: all outputs 0, id_valid 0, if_ready 0, pend_cnt 0. if_ready may rise the first cycle after reset deasserts.
- Latency: accepted in cycle N -> bundle with id_valid=1 in cycle N+1.
- Throughput: 1/cycle with ex_ready held high and no hazards.
- Load-use: `lw $t,...` followed immediately by a reader of $t -> LOAD_LAT bubbles, then the reader is accepted.
- Back-to-back `lw` to different registers: pend_dst/pend_cnt overwritten by the newest load.
- Flush: next cycle id_valid=0, pend_cnt=0; the incoming instruction is not accepted. Flush while ex_ready=0 still drops the held bundle.
- Reset mid-stall or mid-hold returns to the reset state in one cycle.

## Configuration
- DECODE_HAZARD_EN defined: load-use interlock as above.
- Not defined: no pend_dst/pend_cnt logic, stall tied 0; dependent instructions issue back-to-back (compiler inserts delay slots).

## Test plan
- Reset held 3 cycles with if_valid=1 -> if_ready=0, id_valid=0, all controls 0; first post-reset cycle if_ready=1.
- add $17,$31,$0 (0x03E08820) then addi $16,$16,-21846 (0x2210AAAA), ex_ready=1 -> cycle+1 wr_addr=17 reg_wr=1 alu_src=0; cycle+2 wr_addr=16 alu_src=1 imm_ext=0xFFFFAAAA.
- lw $8,0($9) then add $10,$8,$8, LOAD_LAT=1, hazard on -> one bubble (id_valid=0) between them; with LOAD_LAT=2 two bubbles; without DECODE_HAZARD_EN zero bubbles.
- jal 0x0100000 -> link=1 jump=1 wr_addr=31 reg_wr=1 imm26=0x0100000; j -> reg_wr=0.
- Bundle held with ex_ready=0 for 4 cycles -> outputs stable, if_ready=0; flush in cycle 3 -> id_valid=0 next cycle, pend_cnt=0.
- Opcode 111111 -> illegal=1, reg_wr=dm_wr=branch=jump=0, id_valid=1.
